// File: rtl/gfx_mem_arbiter.sv
// gfx_mem_arbiter
//   Arbitrates three burst requesters onto a DDR2 command/write-data FIFO pair
//   and routes returning read beats back to the requester that issued the read.
//   Requester 0 (pixel feeder) has fixed top priority and only reads;
//   requesters 1 (cache) and 2 (graphics engine) share the remaining slots
//   round-robin.
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   reqN_*              : N=0..2 command inputs, reqN_ready is a 1-cycle accept
//   af_*                : address/command FIFO write side
//   wdf_*               : write-data FIFO write side (two 128-bit beats/burst)
//   rdf_valid           : read beat from memory, two beats per read
//   rdN_valid           : beat belongs to requester N
//   tag_error           : sticky, a read beat arrived with no outstanding owner
module gfx_mem_arbiter #(
  parameter int ADDR_W    = 31,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_wr,
  input  logic [255:0]      req0_wdata,
  input  logic [31:0]       req0_wmask,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_wr,
  input  logic [255:0]      req1_wdata,
  input  logic [31:0]       req1_wmask,
  input  logic              req2_valid,
  output logic              req2_ready,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic              req2_wr,
  input  logic [255:0]      req2_wdata,
  input  logic [31:0]       req2_wmask,
  output logic [ADDR_W-1:0] af_addr_din,
  output logic [2:0]        af_cmd_din,
  output logic              af_wr_en,
  input  logic              af_full,
  output logic [127:0]      wdf_din,
  output logic [15:0]       wdf_mask_din,
  output logic              wdf_wr_en,
  input  logic              wdf_full,
  input  logic              rdf_valid,
  output logic              rd0_valid,
  output logic              rd1_valid,
  output logic              rd2_valid,
  output logic              tag_error
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, CMD, WD1} state_t;

  state_t              state_reg;
  logic                last_was1_reg;  // 1: requester 1 won the last shared slot
  logic                wr_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [255:0]        wdata_reg;
  logic [31:0]         wmask_reg;
  logic [1:0]          owner_reg;

  logic [1:0]          tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                beat_reg;
  logic                tag_error_reg;

  logic [2:0]          valid_vec;
  logic [2:0]          wr_vec;
  logic [2:0]          elig_vec;
  logic [2:0]          grant_vec;
  logic [1:0]          grant_id;
  logic [2:0]          rd_vec;
  logic [1:0]          head_owner;
  logic                tag_full;
  logic                tag_empty;
  logic                cmd_fire;
  logic                wd1_fire;
  logic                push;
  logic                pop;
  logic                rd_hit;
  logic                unused_req0_wr;

  // Requester 0 is read-only; its write flag is deliberately ignored.
  assign unused_req0_wr = req0_wr;

  assign valid_vec = {req2_valid, req1_valid, req0_valid};
  assign wr_vec    = {req2_wr, req1_wr, 1'b0};

  assign tag_full  = (count_reg == CNT_W'(TAG_DEPTH));
  assign tag_empty = (count_reg == '0);

  // Reads need a free owner slot; writes never wait on the owner FIFO.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_elig
      assign elig_vec[gi] = valid_vec[gi] & (wr_vec[gi] | ~tag_full);
    end
  endgenerate

  always_comb begin
    grant_vec = 3'b000;
    grant_id  = 2'd0;
    if (!rst && state_reg == IDLE) begin
      if (elig_vec[0]) begin
        grant_vec = 3'b001;
        grant_id  = 2'd0;
      end else if (elig_vec[1] && (!elig_vec[2] || !last_was1_reg)) begin
        grant_vec = 3'b010;
        grant_id  = 2'd1;
      end else if (elig_vec[2]) begin
        grant_vec = 3'b100;
        grant_id  = 2'd2;
      end
    end
  end

  assign {req2_ready, req1_ready, req0_ready} = grant_vec;

  assign cmd_fire = !rst && state_reg == CMD && !af_full && (!wr_reg || !wdf_full);
  assign wd1_fire = !rst && state_reg == WD1 && !wdf_full;
  assign push     = cmd_fire && !wr_reg;

  assign af_wr_en     = cmd_fire;
  assign wdf_wr_en    = (cmd_fire && wr_reg) || wd1_fire;
  assign af_addr_din  = (state_reg == CMD) ? addr_reg : '0;
  assign af_cmd_din   = (state_reg == CMD) ? {2'b00, ~wr_reg} : 3'b000;
  assign wdf_din      = (state_reg == CMD) ? wdata_reg[127:0]  :
                        (state_reg == WD1) ? wdata_reg[255:128] : '0;
  assign wdf_mask_din = (state_reg == CMD) ? wmask_reg[15:0]  :
                        (state_reg == WD1) ? wmask_reg[31:16] : '0;

  // The owner FIFO head has to steer the very beat that arrives, so the tiny
  // owner table is read asynchronously rather than through a registered port.
  assign head_owner = tag_mem[rd_ptr_reg];
  assign rd_hit     = !rst && rdf_valid && !tag_empty;
  assign pop        = rd_hit && beat_reg;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
      assign rd_vec[gi] = rd_hit && (head_owner == 2'(gi));
    end
  endgenerate

  assign {rd2_valid, rd1_valid, rd0_valid} = rd_vec;
  assign tag_error = tag_error_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_reg] <= owner_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_was1_reg <= 1'b0;
      wr_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wmask_reg     <= '0;
      owner_reg     <= 2'd0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      beat_reg      <= 1'b0;
      tag_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|grant_vec) begin
            state_reg <= CMD;
            owner_reg <= grant_id;
            if (grant_id != 2'd0) begin
              last_was1_reg <= (grant_id == 2'd1);
            end
            case (grant_id)
              2'd1: begin
                wr_reg    <= req1_wr;
                addr_reg  <= req1_addr;
                wdata_reg <= req1_wdata;
                wmask_reg <= req1_wmask;
              end
              2'd2: begin
                wr_reg    <= req2_wr;
                addr_reg  <= req2_addr;
                wdata_reg <= req2_wdata;
                wmask_reg <= req2_wmask;
              end
              default: begin
                wr_reg    <= 1'b0;
                addr_reg  <= req0_addr;
                wdata_reg <= req0_wdata;
                wmask_reg <= req0_wmask;
              end
            endcase
          end
        end
        CMD: begin
          if (cmd_fire) begin
            state_reg <= wr_reg ? WD1 : IDLE;
          end
        end
        WD1: begin
          if (wd1_fire) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase

      // Beat counter only advances on beats that have an owner.
      if (rd_hit) begin
        beat_reg <= ~beat_reg;
      end
      if (rdf_valid && tag_empty) begin
        tag_error_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// tb_gfx_mem_arbiter
//   Drives gfx_mem_arbiter with directed scenarios and a randomized phase;
//   every cycle is compared against a transaction-level reference model
//   (one pending command, a queue of outstanding read owners).
module tb_gfx_mem_arbiter;

  localparam int AW = 31;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          v [3];
  logic          w [3];
  logic [AW-1:0] a [3];
  logic [255:0]  d [3];
  logic [31:0]   m [3];
  logic          af_full, wdf_full, rdf_valid;

  logic          rdy0, rdy1, rdy2, af_wr_en, wdf_wr_en, rd0, rd1, rd2, tag_error;
  logic [AW-1:0] af_addr_din;
  logic [2:0]    af_cmd_din;
  logic [127:0]  wdf_din;
  logic [15:0]   wdf_mask_din;

  gfx_mem_arbiter #(.ADDR_W(AW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(rdy0), .req0_addr(a[0]), .req0_wr(w[0]),
    .req0_wdata(d[0]), .req0_wmask(m[0]),
    .req1_valid(v[1]), .req1_ready(rdy1), .req1_addr(a[1]), .req1_wr(w[1]),
    .req1_wdata(d[1]), .req1_wmask(m[1]),
    .req2_valid(v[2]), .req2_ready(rdy2), .req2_addr(a[2]), .req2_wr(w[2]),
    .req2_wdata(d[2]), .req2_wmask(m[2]),
    .af_addr_din(af_addr_din), .af_cmd_din(af_cmd_din), .af_wr_en(af_wr_en),
    .af_full(af_full),
    .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
    .wdf_full(wdf_full),
    .rdf_valid(rdf_valid), .rd0_valid(rd0), .rd1_valid(rd1), .rd2_valid(rd2),
    .tag_error(tag_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit            busy = 0;
  bit            cmd_done = 0;
  bit            cur_wr;
  logic [AW-1:0] cur_addr;
  logic [255:0]  cur_d;
  logic [31:0]   cur_m;
  int            cur_owner;
  int            owner_q[$];
  int            beats_seen = 0;
  bit            m_tag = 0;
  bit            last1 = 0;
  int            grant_log[$];
  int            gcount[3];
  int            af_count = 0;
  bit            regen[3];

  // Last observed outputs
  logic [2:0]    obs_rdy, obs_rd;
  logic          obs_af, obs_wdf, obs_tag;
  logic [AW-1:0] obs_addr;
  logic [2:0]    obs_cmd;
  logic [127:0]  obs_wd;
  logic [15:0]   obs_wm;

  task automatic new_cmd(input int n, input bit wr);
    v[n] = 1'b1;
    w[n] = wr;
    a[n] = AW'($urandom);
    for (int k = 0; k < 8; k++) d[n][k*32 +: 32] = $urandom;
    m[n] = $urandom;
  endtask

  // One clock: called at posedge+1 with inputs set; samples at the falling
  // edge, checks against the model, advances the model, returns at posedge+1.
  task automatic step();
    logic [2:0] exp_rdy, exp_rd;
    bit e_af, e_wdf, fire_cmd, fire_wd1, full;
    bit can[3];
    logic [127:0] e_wd;
    logic [15:0] e_wm;
    int win;
    #4;
    obs_rdy = {rdy2, rdy1, rdy0};
    obs_rd = {rd2, rd1, rd0};
    obs_af = af_wr_en; obs_wdf = wdf_wr_en; obs_tag = tag_error;
    obs_addr = af_addr_din; obs_cmd = af_cmd_din; obs_wd = wdf_din; obs_wm = wdf_mask_din;
    exp_rdy = 3'b000; exp_rd = 3'b000; e_af = 0; e_wdf = 0;
    fire_cmd = 0; fire_wd1 = 0; win = -1; e_wd = '0; e_wm = '0;
    chk("tag_error", obs_tag, m_tag);
    if (!rst) begin
      full = owner_q.size() >= TD;
      if (!busy) begin
        for (int n = 0; n < 3; n++) can[n] = v[n] && ((n != 0 && w[n]) || !full);
        if (can[0]) win = 0;
        else if (can[1] && can[2]) win = last1 ? 2 : 1;
        else if (can[1]) win = 1;
        else if (can[2]) win = 2;
        if (win >= 0) exp_rdy[win] = 1'b1;
      end else if (!cmd_done) begin
        fire_cmd = !af_full && (!cur_wr || !wdf_full);
        e_af = fire_cmd;
        e_wdf = fire_cmd && cur_wr;
        e_wd = cur_d[127:0];
        e_wm = cur_m[15:0];
      end else begin
        fire_wd1 = !wdf_full;
        e_wdf = fire_wd1;
        e_wd = cur_d[255:128];
        e_wm = cur_m[31:16];
      end
      if (rdf_valid && owner_q.size() > 0) exp_rd[owner_q[0]] = 1'b1;
    end
    chk("ready", obs_rdy, exp_rdy);
    chk("af_wr_en", obs_af, e_af);
    chk("wdf_wr_en", obs_wdf, e_wdf);
    chk("rd_valid", obs_rd, exp_rd);
    if (e_af) begin
      chk("af_addr", obs_addr, cur_addr);
      chk("af_cmd", obs_cmd, cur_wr ? 3'b000 : 3'b001);
    end
    if (e_wdf) begin
      chk("wdf_din", obs_wd, e_wd);
      chk("wdf_mask", obs_wm, e_wm);
    end
    if (obs_af) af_count++;
    // model update for the coming edge
    if (rst) begin
      busy = 0; cmd_done = 0; owner_q.delete(); beats_seen = 0; m_tag = 0; last1 = 0;
    end else begin
      if (rdf_valid) begin
        if (owner_q.size() == 0) m_tag = 1;
        else begin
          beats_seen++;
          if (beats_seen == 2) begin
            void'(owner_q.pop_front());
            beats_seen = 0;
          end
        end
      end
      if (win >= 0) begin
        busy = 1; cmd_done = 0; cur_owner = win;
        cur_wr = (win != 0) && w[win];
        cur_addr = a[win]; cur_d = d[win]; cur_m = m[win];
        grant_log.push_back(win);
        if (win != 0) last1 = (win == 1);
      end else if (fire_cmd) begin
        if (cur_wr) cmd_done = 1;
        else begin
          owner_q.push_back(cur_owner);
          busy = 0;
        end
      end else if (fire_wd1) begin
        busy = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      if (obs_rdy[n]) begin
        gcount[n]++;
        if (regen[n]) new_cmd(n, w[n]);
        else v[n] = 1'b0;
      end
    end
  endtask

  task automatic run_until_grant(input int n, input int limit, input string tag);
    int g0;
    g0 = gcount[n];
    for (int i = 0; i < limit && gcount[n] == g0; i++) step();
    chk(tag, gcount[n] > g0, 1'b1);
  endtask

  task automatic drain();
    for (int n = 0; n < 3; n++) begin v[n] = 0; regen[n] = 0; end
    af_full = 0; wdf_full = 0; rdf_valid = 0;
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 100 && owner_q.size() > 0; i++) begin
      rdf_valid = 1;
      step();
    end
    rdf_valid = 0;
  endtask

  initial begin
    logic [AW-1:0] a0;
    logic [31:0] m1;
    int a0c, g0;
    for (int n = 0; n < 3; n++) begin
      v[n] = 0; w[n] = 0; a[n] = '0; d[n] = '0; m[n] = '0; regen[n] = 0; gcount[n] = 0;
    end
    af_full = 0; wdf_full = 0; rdf_valid = 0;
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    step();
    chk("rst_ready", obs_rdy, 3'b000);
    chk("rst_af", obs_af, 1'b0);
    chk("rst_wdf", obs_wdf, 1'b0);
    chk("rst_tag", obs_tag, 1'b0);

    // req0 and req1 reads together: fixed priority for req0
    new_cmd(0, 0); new_cmd(1, 0);
    a0 = a[0];
    step(); chk("p26_t_ready", obs_rdy, 3'b001);
    step(); chk("p26_t1_af", obs_af, 1'b1); chk("p26_t1_cmd", obs_cmd, 3'b001);
    chk("p26_t1_addr", obs_addr, a0);
    step(); chk("p26_t2_ready", obs_rdy, 3'b010);
    step();
    rdf_valid = 1;
    step(); chk("p26_ret0", obs_rd, 3'b001);
    step(); chk("p26_ret1", obs_rd, 3'b001);
    step(); chk("p26_ret2", obs_rd, 3'b010);
    step(); chk("p26_ret3", obs_rd, 3'b010);
    rdf_valid = 0;

    // back-to-back writes from 1 and 2 alternate from reset
    rst = 1; step(); rst = 0;
    grant_log.delete();
    regen[1] = 1; regen[2] = 1;
    new_cmd(1, 1); new_cmd(2, 1);
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) step();
    regen[1] = 0; regen[2] = 0; v[1] = 0; v[2] = 0;
    for (int i = 0; i < 6; i++) step();
    chk("p27_count", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      chk("p27_g0", grant_log[0], 1);
      chk("p27_g1", grant_log[1], 2);
      chk("p27_g2", grant_log[2], 1);
      chk("p27_g3", grant_log[3], 2);
    end

    // write data FIFO stalls during the second beat
    a0c = af_count;
    new_cmd(1, 1);
    m1 = m[1];
    step(); step();
    wdf_full = 1;
    for (int i = 0; i < 3; i++) begin step(); chk("p28_hold", obs_wdf, 1'b0); end
    wdf_full = 0;
    step(); chk("p28_beat1", obs_wdf, 1'b1); chk("p28_mask", obs_wm, m1[31:16]);
    chk("p28_af_once", af_count - a0c, 1);

    // owner FIFO full blocks reads but not writes
    g0 = gcount[2];
    regen[2] = 1;
    new_cmd(2, 0);
    for (int i = 0; i < 200 && gcount[2] - g0 < 8; i++) step();
    regen[2] = 0;
    chk("p29_eight", gcount[2] - g0, 8);
    for (int i = 0; i < 5; i++) begin step(); chk("p29_blocked", obs_rdy[2], 1'b0); end
    new_cmd(1, 1);
    run_until_grant(1, 10, "p29_write_ok");
    rdf_valid = 1;
    step(); chk("p29_ret0", obs_rd, 3'b100);
    step(); chk("p29_ret1", obs_rd, 3'b100);
    rdf_valid = 0;
    run_until_grant(2, 10, "p29_ninth");
    drain();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      af_full = ($urandom_range(3) == 0);
      wdf_full = ($urandom_range(3) == 0);
      rdf_valid = (owner_q.size() > 0) && ($urandom_range(2) == 0);
      for (int n = 0; n < 3; n++)
        if (!v[n] && $urandom_range(2) == 0) new_cmd(n, 1'($urandom_range(1)));
      step();
    end
    drain();

    // orphan read beat sets sticky error
    rdf_valid = 1;
    step(); chk("p30_no_rd", obs_rd, 3'b000);
    rdf_valid = 0;
    step(); chk("p30_tag", obs_tag, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("p30_sticky", obs_tag, 1'b1);
    rst = 1; step(); rst = 0;
    step(); chk("p30_cleared", obs_tag, 1'b0);

    // reset during the second write beat
    new_cmd(1, 1);
    step(); step();
    rst = 1;
    step(); chk("p31_no_beat1", obs_wdf, 1'b0);
    rst = 0;
    step();
    chk("p31_af", obs_af, 1'b0);
    chk("p31_wdf", obs_wdf, 1'b0);
    chk("p31_rdy", obs_rdy, 3'b000);
    chk("p31_rd", obs_rd, 3'b000);
    chk("p31_wd", obs_wd, 128'd0);
    chk("p31_tag", obs_tag, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gfx_mem_arbiter.md
GFX_MEM_ARBITER -- requirements
Module: gfx_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 31, DDR2 burst address width.
REQ-002 The block SHALL have parameter TAG_DEPTH, default 8, read-owner FIFO depth (power of 2).
REQ-003 The block SHALL have clk  input  1  sole clock, cpu_clk_g domain.
REQ-004 The block SHALL have rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have reqN_valid  input  1 (N=0,1,2)  requester N has a command; 0=pixel feeder, 1=cache, 2=graphics engine (line/filler).
REQ-006 The block SHALL have reqN_ready  output  1  one-cycle accept pulse for requester N.
REQ-007 The block SHALL have reqN_addr  input  ADDR_W  burst address; reqN_wr  input  1  1=write, 0=read.
REQ-008 The block SHALL have reqN_wdata  input  256 and reqN_wmask  input  32  write burst; [127:0] is beat 0.
REQ-009 The block SHALL have af_addr_din  output  ADDR_W, af_cmd_din  output  3 (000 write, 001 read), af_wr_en  output  1, af_full  input  1.
REQ-010 The block SHALL have wdf_din  output  128, wdf_mask_din  output  16, wdf_wr_en  output  1, wdf_full  input  1.
REQ-011 The block SHALL have rdf_valid  input  1  read beat from memory; rdN_valid  output  1  beat belongs to requester N.
REQ-012 The block SHALL have tag_error  output  1  sticky: read beat arrived with no outstanding owner.

Function
REQ-013 Requester 0 SHALL have fixed highest priority; requesters 1 and 2 SHALL be round-robin, last-granted pointer toggled on each grant to 1 or 2.
REQ-014 Read requests SHALL NOT be granted while owner FIFO is full; write requests SHALL be unaffected by owner FIFO state; requester 0 is read-only (req0_wr ignored, treated as read).
REQ-015 FSM states SHALL be IDLE, CMD, WD1.
REQ-016 IDLE: if any eligible requester is valid, the winner's reqN_ready SHALL pulse this cycle, addr/wr/wdata/wmask/owner SHALL be latched, next state CMD; else remain IDLE.
REQ-017 CMD: when !af_full and (read or !wdf_full), af_wr_en SHALL assert one cycle with latched address/cmd; for writes wdf_wr_en SHALL assert same cycle with beat 0; reads SHALL push owner ID into owner FIFO same cycle; next state WD1 (write) or IDLE (read). Otherwise hold in CMD, no enables.
REQ-018 WD1: when !wdf_full, wdf_wr_en SHALL assert with beat 1 and mask [31:16]; next IDLE; else hold.
REQ-019 af_wr_en and wdf_wr_en SHALL never assert in IDLE; at most one reqN_ready SHALL be high per cycle.
REQ-020 Each read SHALL return exactly two rdf_valid beats; a 1-bit beat counter SHALL route both to the FIFO head owner (rdN_valid = rdf_valid & head==N, combinational) and pop the FIFO on the second beat.
REQ-021 A push and pop in the same cycle SHALL leave occupancy unchanged; pointers SHALL wrap modulo TAG_DEPTH.
REQ-022 rdf_valid while owner FIFO empty SHALL set tag_error, drive no rdN_valid, and not change the beat counter.
REQ-023 Latency: request valid in cycle t with idle FSM and non-full FIFOs -> reqN_ready at t, af_wr_en at t+1, write beat 1 at t+2.

Reset
REQ-024 On rst the FSM SHALL enter IDLE; all reqN_ready, rdN_valid (except combinational path gated to 0), af_wr_en, wdf_wr_en, tag_error SHALL be 0; owner FIFO empty; beat counter 0; round-robin pointer selects requester 1 first.
REQ-025 rst mid-write (in CMD or WD1) SHALL abandon the command with no further enables; rst SHALL dominate all other inputs in the same cycle.

Verification
REQ-026 req0 and req1 read valid together from reset -> req0_ready at t, af_cmd 001 addr0 at t+1; req1_ready at t+2.
REQ-027 req1, req2 writes held continuously -> grants alternate 1,2,1,2; each produces af_wr_en + beat0 then beat1, mask halves correct.
REQ-028 wdf_full high 3 cycles during WD1 -> FSM holds, beat 1 emitted on first cycle wdf_full low, single af_wr_en total.
REQ-029 Issue 8 reads from req2 with no return -> 9th read not granted, write from req1 still granted; return two beats -> rd2_valid twice, 9th read then granted.
REQ-030 rdf_valid with empty FIFO -> tag_error=1, no rdN_valid, stays 1 until rst.
REQ-031 rst asserted in WD1 -> next cycle IDLE, no wdf_wr_en, all outputs 0.
